csru_multilane: RTL and testbench
=================================

# csru_multilane

User-mode floating-point and fixed-point CSR file for a multi-issue pipeline. It holds `fflags`, `frm` and `fcsr`, plus the optional `vxsat`, `vxrm` and `vcsr`. Exception flags from up to NLANES retiring lanes are accumulated through an M→W pending stage, so flushed instructions never set sticky flags. Committed flag state reaches a CSR read through bypass paths, and the block raises one-cycle dirty pulses for `mstatus.FS`/`VS`.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values are 32 or 64.
- NLANES, 2, number of retire lanes reporting flags; legal range is 1–4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted at 0; clears all state immediately.
- CSRUWriteM  in  1  CSR write strobe; already qualified as valid and not flushed.
- CSRAdrM  in  12  CSR address.
- CSRWriteValM  in  XLEN  CSR write data.
- STATUS_FS  in  2  mstatus.FS; 0 means FP CSRs are off.
- STATUS_VS  in  2  mstatus.VS; 0 means vector CSRs are off. Ignored when the macro is off.
- LaneValidM  in  NLANES  lane i holds a valid FP/fixed-point instruction in M.
- SetFflagsM  in  5*NLANES  per-lane flags; lane i occupies bits [5i+4:5i].
- SetVxsatM  in  NLANES  per-lane saturation flag.
- StallW  in  1  W stage stalled.
- FlushW  in  1  W stage flushed.
- CSRUReadValM  out  XLEN  read data; combinational.
- FRM_REGW  out  3  current rounding mode.
- VXRM_REGW  out  2  fixed-point rounding mode; 0 when the macro is off.
- WriteFRMM, WriteFFLAGSM  out  1  CSR write enables for `frm` and `fflags`.
- SetFSDirtyW, SetVSDirtyW  out  1  registered one-cycle dirty pulses.
- IllegalCSRUAccessM  out  1  illegal-access flag; combinational.

## Operation
Addresses: 0x001 fflags, 0x002 frm, 0x003 fcsr. With the macro on: 0x009 vxsat, 0x00A vxrm, 0x00F vcsr.

Access legality:
- FP CSRs are legal only when STATUS_FS≠0. Vector CSRs are legal only when STATUS_VS≠0.
- An unimplemented address or a disabled class gives IllegalCSRUAccessM=1, CSRUReadValM=0, and no state change.

Write enables:
- WriteFRMM = legal write to 0x002 or 0x003.
- WriteFFLAGSM = legal write to 0x001 or 0x003.
- fcsr field mapping: [7:5]→frm, [4:0]→fflags.
- vcsr field mapping: [2:1]→vxrm, [0]→vxsat.

Pending stage:
- When StallW=0, each edge loads:
  - PendFlags = OR over lanes of (SetFflagsM_i & {5{LaneValidM_i}}).
  - PendVx = OR over lanes of (SetVxsatM_i & LaneValidM_i).
- When StallW=1, the pending registers hold.

Commit:
- On an edge with StallW=0 and FlushW=0: FFLAGS |= PendFlags and VXSAT |= PendVx.
- When FlushW=1, the pending contents are discarded; they are overwritten by the next load.
- When a CSR write to fflags/vxsat in M coincides with a commit, the write wins. The M-stage instruction is younger, so the register takes exactly CSRWriteValM's field.

Read bypass:
- Reads of fflags/fcsr return FFLAGS_REGW | PendFlags.
- Reads of vxsat/vcsr return VXSAT | PendVx.
- The bypass applies whenever FlushW=0.
- Upper bits of read data are zero-filled to XLEN.

Dirty pulses:
- SetFSDirtyW=1 for exactly one cycle after any edge that wrote frm/fflags, or that committed a nonzero PendFlags.
- SetVSDirtyW works the same way for vxrm, vxsat and vcsr writes, and for a committed PendVx.

## Timing
- Reset values are all zero: FRM_REGW, FFLAGS, VXRM_REGW, VXSAT, the pending registers, and both dirty pulses.
- A CSR write in cycle t becomes visible on FRM_REGW/VXRM_REGW and in reads at cycle t+1.
- Flags presented in M at cycle t:
  - load into pending at the end of t;
  - are visible through the bypass at t+1;
  - commit at the end of t+1 if StallW=0 and FlushW=0;
  - are held in FFLAGS_REGW from t+2.
- While StallW is held, the commit is deferred; the bypass value stays constant.
- Reset asserted mid-stall clears pending state; no commit occurs afterward.

## Configuration
- CSRU_VXCSR_EN defined: the vxsat, vxrm and vcsr registers, pending bit, bypass and SetVSDirtyW are implemented.
- CSRU_VXCSR_EN undefined:
  - addresses 0x009, 0x00A and 0x00F are illegal;
  - VXRM_REGW=0 and SetVSDirtyW=0;
  - STATUS_VS, SetVxsatM and the vxsat half of the pending stage are unused.

## Test plan
- Reset, then FS=1 and a write of fcsr=0xE5 → next cycle FRM_REGW=7 and fflags read=0x05. The read of 0x003 returns 0xE5 and SetFSDirtyW pulses once.
- FS=0, read of 0x002 → IllegalCSRUAccessM=1 and CSRUReadValM=0. A write of 0x002 leaves FRM_REGW unchanged.
- NLANES=2: lane0 flags 0x01 and lane1 flags 0x10, both valid, in cycle t → the read at t+1 returns 0x11, and FFLAGS_REGW=0x11 at t+2.
- The same flags as above with FlushW=1 at t+1 → fflags stays 0x00 and SetFSDirtyW stays 0.
- Pending flags 0x04 committing in the same cycle as an fflags write of 0x02 → fflags=0x02.
- With CSRU_VXCSR_EN, VS=1: SetVxsatM lane1 and a vxrm write of 3 → vcsr read=0x7. Without the macro, the same access to 0x00F raises IllegalCSRUAccessM=1.

Source files
------------

// File: rtl/csru_multilane.sv
// User-mode FP/fixed-point CSR file (fflags, frm, fcsr; vxsat, vxrm, vcsr under CSRU_VXCSR_EN)
// with multi-lane flag accumulation through an M->W pending stage and read bypass.
module csru_multilane #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NLANES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CSRUWriteM,
    input  logic [11:0]           CSRAdrM,
    input  logic [XLEN-1:0]       CSRWriteValM,
    input  logic [1:0]            STATUS_FS,
    input  logic [1:0]            STATUS_VS,
    input  logic [NLANES-1:0]     LaneValidM,
    input  logic [5*NLANES-1:0]   SetFflagsM,
    input  logic [NLANES-1:0]     SetVxsatM,
    input  logic                  StallW,
    input  logic                  FlushW,
    output logic [XLEN-1:0]       CSRUReadValM,
    output logic [2:0]            FRM_REGW,
    output logic [1:0]            VXRM_REGW,
    output logic                  WriteFRMM,
    output logic                  WriteFFLAGSM,
    output logic                  SetFSDirtyW,
    output logic                  SetVSDirtyW,
    output logic                  IllegalCSRUAccessM
);

    localparam int unsigned FLAGW = 5;
    localparam int unsigned RDW   = 8;

    localparam logic [11:0] ADR_FFLAGS = 12'h001;
    localparam logic [11:0] ADR_FRM    = 12'h002;
    localparam logic [11:0] ADR_FCSR   = 12'h003;

    logic [FLAGW-1:0] fflags_q;
    logic [FLAGW-1:0] pend_flags_q;
    logic [FLAGW-1:0] pend_flags_d;
    logic [FLAGW-1:0] pend_flags_byp;
    logic             fp_sel;
    logic             fp_ok;
    logic             vx_ok;
    logic             commit;
    logic             fs_dirty_d;
    logic [RDW-1:0]   rd_val;

    assign commit = ~StallW & ~FlushW;

    // FP class decode and write enables
    assign fp_sel       = (CSRAdrM == ADR_FFLAGS) | (CSRAdrM == ADR_FRM) | (CSRAdrM == ADR_FCSR);
    assign fp_ok        = fp_sel & (STATUS_FS != 2'b00);
    assign WriteFRMM    = CSRUWriteM & (STATUS_FS != 2'b00) &
                          ((CSRAdrM == ADR_FRM) | (CSRAdrM == ADR_FCSR));
    assign WriteFFLAGSM = CSRUWriteM & (STATUS_FS != 2'b00) &
                          ((CSRAdrM == ADR_FFLAGS) | (CSRAdrM == ADR_FCSR));
    assign IllegalCSRUAccessM = ~(fp_ok | vx_ok);

    always_comb begin
        pend_flags_d = '0;
        for (int i = 0; i < int'(NLANES); i++) begin
            pend_flags_d |= SetFflagsM[FLAGW*i +: FLAGW] & {FLAGW{LaneValidM[i]}};
        end
    end

    assign pend_flags_byp = FlushW ? '0 : pend_flags_q;
    assign fs_dirty_d     = WriteFRMM | WriteFFLAGSM | (commit & (pend_flags_q != '0));

    // Younger M-stage write overrides the W-stage commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FRM_REGW     <= '0;
            fflags_q     <= '0;
            pend_flags_q <= '0;
            SetFSDirtyW  <= 1'b0;
        end else begin
            if (WriteFRMM)
                FRM_REGW <= (CSRAdrM == ADR_FCSR) ? CSRWriteValM[7:5] : CSRWriteValM[2:0];
            if (WriteFFLAGSM)
                fflags_q <= CSRWriteValM[4:0];
            else if (commit)
                fflags_q <= fflags_q | pend_flags_q;
            if (!StallW)
                pend_flags_q <= pend_flags_d;
            SetFSDirtyW <= fs_dirty_d;
        end
    end

`ifdef CSRU_VXCSR_EN
    localparam logic [11:0] ADR_VXSAT = 12'h009;
    localparam logic [11:0] ADR_VXRM  = 12'h00A;
    localparam logic [11:0] ADR_VCSR  = 12'h00F;

    logic vxsat_q;
    logic pend_vx_q;
    logic pend_vx_d;
    logic pend_vx_byp;
    logic vx_sel;
    logic vx_wr;
    logic wr_vxsat;
    logic wr_vxrm;
    logic vs_dirty_d;

    assign vx_sel      = (CSRAdrM == ADR_VXSAT) | (CSRAdrM == ADR_VXRM) | (CSRAdrM == ADR_VCSR);
    assign vx_ok       = vx_sel & (STATUS_VS != 2'b00);
    assign vx_wr       = CSRUWriteM & vx_ok;
    assign wr_vxsat    = vx_wr & ((CSRAdrM == ADR_VXSAT) | (CSRAdrM == ADR_VCSR));
    assign wr_vxrm     = vx_wr & ((CSRAdrM == ADR_VXRM) | (CSRAdrM == ADR_VCSR));
    assign pend_vx_d   = |(SetVxsatM & LaneValidM);
    assign pend_vx_byp = ~FlushW & pend_vx_q;
    assign vs_dirty_d  = vx_wr | (commit & pend_vx_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            VXRM_REGW   <= '0;
            vxsat_q     <= 1'b0;
            pend_vx_q   <= 1'b0;
            SetVSDirtyW <= 1'b0;
        end else begin
            if (wr_vxrm)
                VXRM_REGW <= (CSRAdrM == ADR_VCSR) ? CSRWriteValM[2:1] : CSRWriteValM[1:0];
            if (wr_vxsat)
                vxsat_q <= CSRWriteValM[0];
            else if (commit)
                vxsat_q <= vxsat_q | pend_vx_q;
            if (!StallW)
                pend_vx_q <= pend_vx_d;
            SetVSDirtyW <= vs_dirty_d;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^CSRWriteValM[XLEN-1:8];

    always_comb begin
        rd_val = '0;
        case (CSRAdrM)
            ADR_FFLAGS: rd_val = RDW'(fflags_q | pend_flags_byp);
            ADR_FRM:    rd_val = RDW'(FRM_REGW);
            ADR_FCSR:   rd_val = {FRM_REGW, fflags_q | pend_flags_byp};
            ADR_VXSAT:  rd_val = RDW'(vxsat_q | pend_vx_byp);
            ADR_VXRM:   rd_val = RDW'(VXRM_REGW);
            ADR_VCSR:   rd_val = RDW'({VXRM_REGW, vxsat_q | pend_vx_byp});
            default:    rd_val = '0;
        endcase
    end
`else
    assign vx_ok       = 1'b0;
    assign VXRM_REGW   = 2'b00;
    assign SetVSDirtyW = 1'b0;

    logic unused_vx;
    assign unused_vx = ^{STATUS_VS, SetVxsatM, CSRWriteValM[XLEN-1:8]};

    always_comb begin
        rd_val = '0;
        case (CSRAdrM)
            ADR_FFLAGS: rd_val = RDW'(fflags_q | pend_flags_byp);
            ADR_FRM:    rd_val = RDW'(FRM_REGW);
            ADR_FCSR:   rd_val = {FRM_REGW, fflags_q | pend_flags_byp};
            default:    rd_val = '0;
        endcase
    end
`endif

    assign CSRUReadValM = IllegalCSRUAccessM ? '0 : XLEN'(rd_val);

endmodule

// File: tb/tb_csru_multilane.sv
// Directed bench for csru_multilane: expected values queued at drive time, popped at sample time.
module tb_csru_multilane;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NLANES = 2;

    logic                clk;
    logic                reset;
    logic                CSRUWriteM;
    logic [11:0]         CSRAdrM;
    logic [XLEN-1:0]     CSRWriteValM;
    logic [1:0]          STATUS_FS;
    logic [1:0]          STATUS_VS;
    logic [NLANES-1:0]   LaneValidM;
    logic [5*NLANES-1:0] SetFflagsM;
    logic [NLANES-1:0]   SetVxsatM;
    logic                StallW;
    logic                FlushW;
    logic [XLEN-1:0]     CSRUReadValM;
    logic [2:0]          FRM_REGW;
    logic [1:0]          VXRM_REGW;
    logic                WriteFRMM;
    logic                WriteFFLAGSM;
    logic                SetFSDirtyW;
    logic                SetVSDirtyW;
    logic                IllegalCSRUAccessM;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    csru_multilane #(.XLEN(XLEN), .NLANES(NLANES)) dut (
        .clk                (clk),
        .reset              (reset),
        .CSRUWriteM         (CSRUWriteM),
        .CSRAdrM            (CSRAdrM),
        .CSRWriteValM       (CSRWriteValM),
        .STATUS_FS          (STATUS_FS),
        .STATUS_VS          (STATUS_VS),
        .LaneValidM         (LaneValidM),
        .SetFflagsM         (SetFflagsM),
        .SetVxsatM          (SetVxsatM),
        .StallW             (StallW),
        .FlushW             (FlushW),
        .CSRUReadValM       (CSRUReadValM),
        .FRM_REGW           (FRM_REGW),
        .VXRM_REGW          (VXRM_REGW),
        .WriteFRMM          (WriteFRMM),
        .WriteFFLAGSM       (WriteFFLAGSM),
        .SetFSDirtyW        (SetFSDirtyW),
        .SetVSDirtyW        (SetVSDirtyW),
        .IllegalCSRUAccessM (IllegalCSRUAccessM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic clr_lanes();
        LaneValidM = '0;
        SetFflagsM = '0;
        SetVxsatM  = '0;
    endtask

    initial begin
        reset = 1'b0; CSRUWriteM = 1'b0; CSRAdrM = '0; CSRWriteValM = '0;
        STATUS_FS = 2'd0; STATUS_VS = 2'd0; StallW = 1'b0; FlushW = 1'b0;
        clr_lanes();
        #3;
        push(0); chk("rst_frm", 64'(FRM_REGW));
        push(0); chk("rst_vxrm", 64'(VXRM_REGW));
        push(0); chk("rst_fsdirty", 64'(SetFSDirtyW));
        push(0); chk("rst_vsdirty", 64'(SetVSDirtyW));
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // fcsr write 0xE5
        STATUS_FS = 2'd1; CSRUWriteM = 1'b1; CSRAdrM = 12'h003; CSRWriteValM = 64'hE5;
        settle();
        push(1); chk("fcsr_wr_frm_en", 64'(WriteFRMM));
        push(1); chk("fcsr_wr_ff_en", 64'(WriteFFLAGSM));
        push(0); chk("fcsr_legal", 64'(IllegalCSRUAccessM));
        cyc();
        CSRUWriteM = 1'b0; CSRAdrM = 12'h002;
        settle();
        push(7); chk("frm_after_fcsr", 64'(FRM_REGW));
        push(7); chk("rd_frm", CSRUReadValM);
        push(1); chk("fsdirty_fcsr", 64'(SetFSDirtyW));
        CSRAdrM = 12'h001; settle();
        push(64'h05); chk("rd_fflags", CSRUReadValM);
        CSRAdrM = 12'h003; settle();
        push(64'hE5); chk("rd_fcsr", CSRUReadValM);
        cyc(); settle();
        push(0); chk("fsdirty_one_cycle", 64'(SetFSDirtyW));

        // FS off: illegal, write ignored
        STATUS_FS = 2'd0; CSRAdrM = 12'h002; CSRUWriteM = 1'b1; CSRWriteValM = 64'h3;
        settle();
        push(1); chk("fs_off_illegal", 64'(IllegalCSRUAccessM));
        push(0); chk("fs_off_rd", CSRUReadValM);
        push(0); chk("fs_off_wren", 64'(WriteFRMM));
        cyc();
        CSRUWriteM = 1'b0; settle();
        push(7); chk("fs_off_frm_kept", 64'(FRM_REGW));
        push(0); chk("fs_off_no_dirty", 64'(SetFSDirtyW));
        STATUS_FS = 2'd1;

        // two-lane accumulation
        CSRUWriteM = 1'b1; CSRAdrM = 12'h001; CSRWriteValM = '0;
        cyc();
        CSRUWriteM = 1'b0;
        cyc();
        LaneValidM = 2'b11; SetFflagsM = {5'h10, 5'h01};
        cyc();
        clr_lanes(); CSRAdrM = 12'h001; settle();
        push(64'h11); chk("lanes_bypass_t1", CSRUReadValM);
        push(0); chk("lanes_no_dirty_t1", 64'(SetFSDirtyW));
        cyc(); settle();
        push(64'h11); chk("lanes_commit_t2", CSRUReadValM);
        push(1); chk("lanes_dirty_t2", 64'(SetFSDirtyW));
        cyc(); settle();
        push(0); chk("lanes_dirty_end", 64'(SetFSDirtyW));

        // invalid lane is masked
        LaneValidM = 2'b01; SetFflagsM = {5'h08, 5'h02};
        cyc();
        clr_lanes(); settle();
        push(64'h13); chk("lane_mask", CSRUReadValM);
        cyc();

        // flush discards pending flags
        CSRUWriteM = 1'b1; CSRAdrM = 12'h001; CSRWriteValM = '0;
        cyc();
        CSRUWriteM = 1'b0;
        cyc();
        LaneValidM = 2'b11; SetFflagsM = {5'h10, 5'h01};
        cyc();
        clr_lanes(); FlushW = 1'b1; settle();
        push(0); chk("flush_no_bypass", CSRUReadValM);
        cyc();
        FlushW = 1'b0; settle();
        push(0); chk("flush_fflags", CSRUReadValM);
        push(0); chk("flush_no_dirty", 64'(SetFSDirtyW));

        // write beats concurrent commit
        LaneValidM = 2'b01; SetFflagsM = {5'h00, 5'h04};
        cyc();
        clr_lanes(); settle();
        push(64'h04); chk("pend_04_bypass", CSRUReadValM);
        CSRUWriteM = 1'b1; CSRWriteValM = 64'h02;
        cyc();
        CSRUWriteM = 1'b0; settle();
        push(64'h02); chk("write_wins", CSRUReadValM);
        push(1); chk("write_wins_dirty", 64'(SetFSDirtyW));

        // stall defers commit, bypass constant
        LaneValidM = 2'b01; SetFflagsM = {5'h00, 5'h08};
        cyc();
        clr_lanes(); StallW = 1'b1; settle();
        push(64'h0A); chk("stall_bypass_0", CSRUReadValM);
        cyc(); settle();
        push(64'h0A); chk("stall_bypass_1", CSRUReadValM);
        push(0); chk("stall_no_dirty", 64'(SetFSDirtyW));
        StallW = 1'b0;
        cyc(); settle();
        push(64'h0A); chk("stall_commit", CSRUReadValM);
        push(1); chk("stall_commit_dirty", 64'(SetFSDirtyW));

        // reset mid-stall clears pending
        LaneValidM = 2'b01; SetFflagsM = {5'h00, 5'h10};
        cyc();
        clr_lanes(); StallW = 1'b1; settle();
        push(64'h1A); chk("pre_reset_bypass", CSRUReadValM);
        reset = 1'b0; settle();
        push(0); chk("mid_stall_reset_rd", CSRUReadValM);
        push(0); chk("mid_stall_reset_frm", 64'(FRM_REGW));
        reset = 1'b1; StallW = 1'b0;
        cyc(); settle();
        push(0); chk("post_reset_no_commit", CSRUReadValM);
        push(0); chk("post_reset_no_dirty", 64'(SetFSDirtyW));

`ifdef CSRU_VXCSR_EN
        STATUS_VS = 2'd1;
        LaneValidM = 2'b10; SetVxsatM = 2'b10;
        CSRUWriteM = 1'b1; CSRAdrM = 12'h00A; CSRWriteValM = 64'h3;
        settle();
        push(0); chk("vxrm_wr_not_frm", 64'(WriteFRMM));
        push(0); chk("vxrm_legal", 64'(IllegalCSRUAccessM));
        cyc();
        clr_lanes(); CSRUWriteM = 1'b0; CSRAdrM = 12'h00F; settle();
        push(64'h7); chk("rd_vcsr", CSRUReadValM);
        push(3); chk("vxrm_reg", 64'(VXRM_REGW));
        push(1); chk("vsdirty", 64'(SetVSDirtyW));
`else
        STATUS_VS = 2'd1;
        LaneValidM = 2'b10; SetVxsatM = 2'b10;
        CSRAdrM = 12'h00F; settle();
        push(1); chk("vcsr_illegal", 64'(IllegalCSRUAccessM));
        push(0); chk("vcsr_rd_zero", CSRUReadValM);
        cyc();
        clr_lanes(); settle();
        push(0); chk("vxrm_zero", 64'(VXRM_REGW));
        push(0); chk("vsdirty_zero", 64'(SetVSDirtyW));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
